// File: rtl/tm1638_key_scan_memmap.sv
// TM1638 key reader: bit-bangs command 0x42, shifts in 4 key bytes, decodes the
// 8 buttons and posts {buttons, raw bytes} through a byte-wide memory write port.
module tm1638_key_scan_memmap #(
  parameter int          CLOCK_FREQ_MHz  = 12,
  parameter int          HALF_BIT_CYCLES = CLOCK_FREQ_MHz,
  parameter int          TWAIT_CYCLES    = 2 * CLOCK_FREQ_MHz,
  parameter logic [15:0] KEY_BASE_ADDR   = 16'h0300
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_write_addr,
  output logic [7:0]  o_write_data,
  output logic        o_write_en,
  output logic [7:0]  o_btn_state,
  output logic        o_changed,
  output logic        o_tm1638_clk,
  output logic        o_tm1638_stb,
  inout  wire         io_tm1638_data,
  output logic        o_idle
);

  localparam int CW = 16;
  localparam logic [7:0]    CMD_READ_KEYS = 8'h42;
  localparam logic [CW-1:0] H_CNT  = CW'(HALF_BIT_CYCLES);
  localparam logic [CW-1:0] H_LAST = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [CW-1:0] B_LAST = CW'(2 * HALF_BIT_CYCLES - 1);
  localparam logic [CW-1:0] W_LAST = CW'(TWAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STB_LOW, S_CMD, S_WAIT_TW, S_READ, S_STB_HIGH, S_WRITE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     bit_q, bit_d;
  logic [31:0]    raw_q, raw_d;
  logic           clk_q, clk_d;
  logic           stb_q, stb_d;
  logic           dio_oe_q, dio_oe_d;
  logic           dio_out_q, dio_out_d;
  logic           wen_q, wen_d;
  logic [15:0]    waddr_q, waddr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [7:0]     btn_q, btn_d;
  logic           changed_q, changed_d;
  logic [7:0]     decoded;

  // S1-S4 live in bit 0 of bytes 0-3, S5-S8 in bit 4 of bytes 0-3.
  for (genvar gi = 0; gi < 8; gi++) begin : g_decode
    assign decoded[gi] = raw_q[(gi % 4) * 8 + (gi / 4) * 4];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      raw_q     <= '0;
      clk_q     <= 1'b1;
      stb_q     <= 1'b1;
      dio_oe_q  <= 1'b0;
      dio_out_q <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      btn_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      raw_q     <= raw_d;
      clk_q     <= clk_d;
      stb_q     <= stb_d;
      dio_oe_q  <= dio_oe_d;
      dio_out_q <= dio_out_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      btn_q     <= btn_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    raw_d   = raw_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (i_en) state_d = S_STB_LOW;
      end
      S_STB_LOW: begin
        if (cnt_q == H_LAST) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
      end
      S_CMD: begin
        if (cnt_q == B_LAST) begin
          cnt_d = '0;
          if (bit_q == 5'd7) begin
            state_d = S_WAIT_TW;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_WAIT_TW: begin
        if (cnt_q == W_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        // First cycle of CLK high is the sampling point.
        if (cnt_q == H_CNT) raw_d[bit_q] = io_tm1638_data;
        if (cnt_q == B_LAST) begin
          cnt_d = '0;
          if (bit_q == 5'd31) begin
            state_d = S_STB_HIGH;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_STB_HIGH: begin
        if (cnt_q == H_LAST) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end
      end
      S_WRITE: begin
        if (cnt_q == CW'(4)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they are registered yet aligned with it.
  always_comb begin
    clk_d     = 1'b1;
    stb_d     = 1'b1;
    dio_oe_d  = 1'b0;
    dio_out_d = 1'b0;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    btn_d     = btn_q;
    changed_d = 1'b0;
    case (state_d)
      S_STB_LOW, S_WAIT_TW: stb_d = 1'b0;
      S_CMD: begin
        stb_d     = 1'b0;
        clk_d     = (cnt_d >= H_CNT);
        dio_oe_d  = 1'b1;
        dio_out_d = CMD_READ_KEYS[bit_d[2:0]];
      end
      S_READ: begin
        stb_d = 1'b0;
        clk_d = (cnt_d >= H_CNT);
      end
      S_WRITE: begin
        wen_d   = 1'b1;
        waddr_d = KEY_BASE_ADDR + cnt_d;
        case (cnt_d[2:0])
          3'd0:    wdata_d = btn_q;
          3'd1:    wdata_d = raw_q[7:0];
          3'd2:    wdata_d = raw_q[15:8];
          3'd3:    wdata_d = raw_q[23:16];
          default: wdata_d = raw_q[31:24];
        endcase
      end
      default: ;
    endcase
    if (state_q == S_READ && state_d == S_STB_HIGH) begin
      btn_d     = decoded;
      changed_d = (decoded != btn_q);
    end
  end

  assign io_tm1638_data = dio_oe_q ? dio_out_q : 1'bz;
  assign o_tm1638_clk   = clk_q;
  assign o_tm1638_stb   = stb_q;
  assign o_write_en     = wen_q;
  assign o_write_addr   = waddr_q;
  assign o_write_data   = wdata_q;
  assign o_btn_state    = btn_q;
  assign o_changed      = changed_q;
  assign o_idle         = (state_q == S_IDLE);

endmodule

// File: tb/tb_tm1638_key_scan_memmap.sv
// Bench for tm1638_key_scan_memmap: a reactive TM1638 key model drives DIO,
// each scan is observed as events (edges, pulses, writes) and checked by cycle.
module tb_tm1638_key_scan_memmap;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic [15:0] o_write_addr;
  logic [7:0]  o_write_data;
  logic        o_write_en;
  logic [7:0]  o_btn_state;
  logic        o_changed;
  logic        o_tm1638_clk;
  logic        o_tm1638_stb;
  logic        o_idle;
  wire         dio;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] key_word = '0;
  logic        drv_en = 1'b0;
  logic        drv_val = 1'b0;
  logic        m_pclk = 1'b1;
  int          m_rises = 0;

  tm1638_key_scan_memmap dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .o_write_addr  (o_write_addr),
    .o_write_data  (o_write_data),
    .o_write_en    (o_write_en),
    .o_btn_state   (o_btn_state),
    .o_changed     (o_changed),
    .o_tm1638_clk  (o_tm1638_clk),
    .o_tm1638_stb  (o_tm1638_stb),
    .io_tm1638_data(dio),
    .o_idle        (o_idle)
  );

  assign dio = drv_en ? drv_val : 1'bz;
  pullup (dio);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key chip: after 8 command clocks, present key bit j on each CLK fall.
  always @(negedge clk) begin
    if (o_tm1638_stb) begin
      drv_en  <= 1'b0;
      m_rises <= 0;
    end else begin
      if (!m_pclk && o_tm1638_clk) m_rises <= m_rises + 1;
      if (m_pclk && !o_tm1638_clk && m_rises >= 8 && m_rises < 40) begin
        drv_en  <= 1'b1;
        drv_val <= key_word[m_rises - 8];
      end
    end
    m_pclk <= o_tm1638_clk;
  end

  typedef struct packed {
    logic [31:0] keys;
    logic [7:0]  btn;
    logic        chg;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Button k pressed iff key byte (k mod 4) has bit 0 (k<4) or bit 4 (k>=4) set.
  function automatic logic [7:0] model_btn(input logic [31:0] w);
    logic [7:0] r;
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b    = 8'(w >> (8 * (k % 4)));
      r[k] = (k < 4) ? b[0] : b[4];
    end
    return r;
  endfunction

  // Starts a scan at the current cycle N and observes N+1..N+1014.
  task automatic do_scan(input logic [7:0] exp_btn, input bit exp_chg,
                         input logic [7:0] prev_btn, input bit hold);
    int n, stb_fall, stb_rise, bad, exp_t;
    int rise_t[$];
    logic rise_d[$];
    int chg_t[$];
    int wr_t[$];
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    int idle_t[$];
    logic pclk, d204, d205, d228;
    logic [7:0] b996, b997;
    logic [7:0] exp_wd [5];
    logic [7:0] cmd;
    n = cyc;
    i_en = 1'b1;
    pclk = 1'b1;
    stb_fall = -1;
    stb_rise = -1;
    d204 = 1'b1; d205 = 1'b0; d228 = 1'b0;
    b996 = '0; b997 = '0;
    for (int t = 1; t <= 1014; t++) begin
      @(negedge clk); #1;
      if (t == 1 && !hold) i_en = 1'b0;
      if (hold && t == 300) i_en = 1'b0;
      if (hold && t == 600) i_en = 1'b1;
      if (stb_fall < 0 && !o_tm1638_stb) stb_fall = t;
      if (stb_fall >= 0 && stb_rise < 0 && o_tm1638_stb) stb_rise = t;
      if (!pclk && o_tm1638_clk && !o_tm1638_stb) begin
        rise_t.push_back(t);
        rise_d.push_back(dio);
      end
      pclk = o_tm1638_clk;
      if (t == 204) d204 = dio;
      if (t == 205) d205 = dio;
      if (t == 228) d228 = dio;
      if (t == 996) b996 = o_btn_state;
      if (t == 997) b997 = o_btn_state;
      if (o_changed) chg_t.push_back(t);
      if (o_write_en) begin
        wr_t.push_back(t);
        wr_a.push_back(o_write_addr);
        wr_d.push_back(o_write_data);
      end
      if (o_idle) idle_t.push_back(t);
    end
    chk("stb_fall", stb_fall, 1);
    chk("stb_rise", stb_rise, 997);
    chk("clk_rise_count", rise_t.size(), 40);
    bad = 0;
    for (int i = 0; i < rise_t.size(); i++) begin
      exp_t = (i < 8) ? 25 + 24 * i : 241 + 24 * (i - 8);
      if (rise_t[i] != exp_t) bad++;
    end
    chk("clk_rise_timing_errs", bad, 0);
    cmd = 8'h42;
    if (rise_d.size() >= 8)
      for (int i = 0; i < 8; i++) chk($sformatf("cmd_bit%0d", i), int'(rise_d[i]), int'(cmd[i]));
    chk("dio_last_cmd_bit", int'(d204), 0);
    chk("dio_released_n205", int'(d205), 1);
    chk("dio_released_n228", int'(d228), 1);
    chk("changed_pulses", chg_t.size(), exp_chg ? 1 : 0);
    if (exp_chg && chg_t.size() > 0) chk("changed_time", chg_t[0], 997);
    chk("btn_before", int'(b996), int'(prev_btn));
    chk("btn_after", int'(b997), int'(exp_btn));
    exp_wd[0] = exp_btn;
    for (int i = 1; i < 5; i++) exp_wd[i] = key_word[8 * (i - 1) +: 8];
    chk("write_count", wr_t.size(), 5);
    for (int i = 0; i < wr_t.size() && i < 5; i++) begin
      chk($sformatf("wr%0d_time", i), wr_t[i], 1009 + i);
      chk($sformatf("wr%0d_addr", i), int'(wr_a[i]), 32'h0300 + i);
      chk($sformatf("wr%0d_data", i), int'(wr_d[i]), int'(exp_wd[i]));
    end
    chk("idle_cycles", idle_t.size(), 1);
    if (idle_t.size() > 0) chk("idle_time", idle_t[0], 1014);
  endtask

  vec_t vecs [7];
  logic [7:0] prev;
  logic [7:0] eb;
  int bad_w, bad_s;

  initial begin
    vecs[0] = '{keys: 32'h1000_0001, btn: 8'h81, chg: 1'b1};
    vecs[1] = '{keys: 32'h1000_0001, btn: 8'h81, chg: 1'b0};
    vecs[2] = '{keys: 32'h1111_1111, btn: 8'hFF, chg: 1'b1};
    vecs[3] = '{keys: 32'hEEEE_EEEE, btn: 8'h00, chg: 1'b1};
    vecs[4] = '{keys: 32'h0000_1000, btn: 8'h20, chg: 1'b1};
    vecs[5] = '{keys: 32'h0001_0000, btn: 8'h04, chg: 1'b1};
    vecs[6] = '{keys: 32'h0000_0010, btn: 8'h10, chg: 1'b1};

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stb", int'(o_tm1638_stb), 1);
    chk("rst_clk", int'(o_tm1638_clk), 1);
    chk("rst_dio", int'(dio), 1);
    chk("rst_wen", int'(o_write_en), 0);
    chk("rst_btn", int'(o_btn_state), 0);
    chk("rst_idle", int'(o_idle), 1);
    i_rst = 1'b0;
    @(negedge clk); #1;

    prev = 8'h00;
    for (int v = 0; v < 7; v++) begin
      key_word = vecs[v].keys;
      do_scan(vecs[v].btn, vecs[v].chg, prev, 1'b0);
      $display("[TB] vec %0d keys=%08h btn=%02h chg=%0d", v, vecs[v].keys, vecs[v].btn, vecs[v].chg);
      prev = vecs[v].btn;
    end

    for (int r = 0; r < 6; r++) begin
      if (r % 3 != 2) key_word = $urandom;
      eb = model_btn(key_word);
      do_scan(eb, eb != prev, prev, 1'b0);
      $display("[TB] rnd %0d keys=%08h btn=%02h", r, key_word, eb);
      prev = eb;
    end

    // i_en held high and toggled mid-scan, then an immediate second scan.
    key_word = 32'h0000_0001;
    eb = model_btn(key_word);
    do_scan(eb, eb != prev, prev, 1'b1);
    $display("[TB] held-enable scan btn=%02h", eb);
    prev = eb;
    do_scan(eb, 1'b0, prev, 1'b0);
    $display("[TB] back-to-back scan btn=%02h", eb);

    // Reset at N+500 aborts the scan.
    key_word = 32'h1111_1111;
    i_en = 1'b1;
    for (int t = 1; t <= 500; t++) begin
      @(negedge clk); #1;
      if (t == 1) i_en = 1'b0;
      if (t == 499) chk("midrst_btn_pre", int'(o_btn_state), int'(prev));
    end
    i_rst = 1'b1;
    @(negedge clk); #1;
    i_rst = 1'b0;
    chk("midrst_stb", int'(o_tm1638_stb), 1);
    chk("midrst_clk", int'(o_tm1638_clk), 1);
    chk("midrst_dio", int'(dio), 1);
    chk("midrst_wen", int'(o_write_en), 0);
    chk("midrst_btn", int'(o_btn_state), 0);
    chk("midrst_idle", int'(o_idle), 1);
    bad_w = 0;
    bad_s = 0;
    for (int t = 0; t < 1100; t++) begin
      @(negedge clk); #1;
      if (o_write_en) bad_w++;
      if (!o_tm1638_stb || !o_idle) bad_s++;
    end
    chk("midrst_no_writes", bad_w, 0);
    chk("midrst_stays_idle", bad_s, 0);
    $display("[TB] mid-scan reset checked");
    prev = 8'h00;

    key_word = 32'h0000_0001;
    eb = model_btn(key_word);
    do_scan(eb, 1'b1, prev, 1'b0);
    $display("[TB] post-reset scan btn=%02h", eb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
